// File: rtl/ypkg.sv
`default_nettype none
// ============================================================================
// Package  : ypkg
// Purpose  : Shared widths, slot field offsets and FSM encoding for the Y SRAM
//            write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
package ypkg;

  localparam int ADDR_W  = 11;
  localparam int VAL_W   = 24;
  localparam int SLOTS   = 4;
  localparam int SLOT_W  = 64;
  localparam int ROW_W   = SLOTS * SLOT_W;
  localparam int COL_LSB = 48;
  localparam int RE_LSB  = 24;
  localparam int IM_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_D = 3'd1,
    S_WT_D = 3'd2,
    S_WR_D = 3'd3,
    S_RD_N = 3'd4,
    S_WT_N = 3'd5,
    S_WR_N = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/yslot_merge.sv
`default_nettype none
// ============================================================================
// Module   : yslot_merge
// Purpose  : Replaces the value field of the lowest selected slot in a Y row,
//            keeping the column tag; flags a select that is not one-hot.
// Revision : 1.0 - initial release
// ============================================================================
module yslot_merge
  import ypkg::*;
(
  input  logic [ROW_W-1:0]   row,
  input  logic [SLOTS-1:0]   one_hot,
  input  logic [2*VAL_W-1:0] val,
  output logic [ROW_W-1:0]   new_row,
  output logic               err
);

  logic [SLOTS-1:0] sel;

  // Isolate the lowest set bit so a multi-bit select writes exactly one slot.
  assign sel = one_hot & (~one_hot + SLOTS'(1));
  assign err = (one_hot == '0) || ((one_hot & (one_hot - SLOTS'(1))) != '0);

  generate
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
      assign new_row[k*SLOT_W +: SLOT_W] = sel[k]
        ? {row[k*SLOT_W+COL_LSB +: SLOT_W-COL_LSB],
           val[2*VAL_W-1:VAL_W],
           val[VAL_W-1:0]}
        : row[k*SLOT_W +: SLOT_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ysram_writeback.sv
`default_nettype none
// ============================================================================
// Module   : ysram_writeback
// Purpose  : Read-modify-writes one admittance value into the diagonal slot and
//            its saturated negation into the off-diagonal slot of the Y SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module ysram_writeback
  import ypkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [2*VAL_W-1:0]  wb_yVal,
  input  logic [ADDR_W-1:0]   wb_diagAddr,
  input  logic [ADDR_W-1:0]   wb_nonDiagAddr,
  input  logic [SLOTS-1:0]    wb_diagOneHot,
  input  logic [SLOTS-1:0]    wb_nonDiagOneHot,
  output logic [ADDR_W-1:0]   wb_memAddr,
  output logic                wb_memRdEn,
  output logic                wb_memWrEn,
  output logic [ROW_W-1:0]    wb_memWrData,
  input  logic [ROW_W-1:0]    wb_memRdData,
  output logic                wb_done,
  output logic                wb_err
);

  state_t state, state_nx;

  logic [2*VAL_W-1:0] y_val;
  logic [ADDR_W-1:0]  diag_addr;
  logic [ADDR_W-1:0]  nd_addr;
  logic [SLOTS-1:0]   diag_oh;
  logic [SLOTS-1:0]   nd_oh;
  logic               wr_ok;

  logic [2*VAL_W-1:0] neg_val;
  logic [2*VAL_W-1:0] m_val;
  logic [SLOTS-1:0]   m_oh;
  logic [ROW_W-1:0]   m_row;
  logic               m_err;
  logic               in_nd;

  // The most negative component has no positive twin; clamp it instead.
  function automatic logic [VAL_W-1:0] neg_sat(input logic [VAL_W-1:0] x);
    if (x == {1'b1, {(VAL_W-1){1'b0}}})
      return {1'b0, {(VAL_W-1){1'b1}}};
    return (~x) + VAL_W'(1);
  endfunction

  assign neg_val = {neg_sat(y_val[2*VAL_W-1:VAL_W]), neg_sat(y_val[VAL_W-1:0])};
  assign in_nd   = (state == S_WT_N);
  assign m_val   = in_nd ? neg_val : y_val;
  assign m_oh    = in_nd ? nd_oh : diag_oh;

  yslot_merge u_merge (
    .row     (wb_memRdData),
    .one_hot (m_oh),
    .val     (m_val),
    .new_row (m_row),
    .err     (m_err)
  );

  always_comb begin
    state_nx   = state;
    wb_ready   = 1'b0;
    wb_memRdEn = 1'b0;
    wb_memWrEn = 1'b0;
    case (state)
      S_IDLE: begin
        wb_ready = 1'b1;
        if (wb_valid) state_nx = S_RD_D;
      end
      S_RD_D: begin
        wb_memRdEn = 1'b1;
        state_nx   = S_WT_D;
      end
      S_WT_D: state_nx = S_WR_D;
      S_WR_D: begin
        wb_memWrEn = wr_ok;
        state_nx   = S_RD_N;
      end
      S_RD_N: begin
        wb_memRdEn = 1'b1;
        state_nx   = S_WT_N;
      end
      S_WT_N: state_nx = S_WR_N;
      S_WR_N: begin
        wb_memWrEn = wr_ok;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      y_val        <= '0;
      diag_addr    <= '0;
      nd_addr      <= '0;
      diag_oh      <= '0;
      nd_oh        <= '0;
      wr_ok        <= 1'b0;
      wb_memAddr   <= '0;
      wb_memWrData <= '0;
      wb_done      <= 1'b0;
      wb_err       <= 1'b0;
    end else begin
      state   <= state_nx;
      wb_done <= (state == S_WR_N);
      case (state)
        S_IDLE: begin
          if (wb_valid) begin
            y_val      <= wb_yVal;
            diag_addr  <= wb_diagAddr;
            nd_addr    <= wb_nonDiagAddr;
            diag_oh    <= wb_diagOneHot;
            nd_oh      <= wb_nonDiagOneHot;
            wb_memAddr <= wb_diagAddr;
          end
        end
        // Read data arrives here; merge it straight into the write-data register.
        S_WT_D, S_WT_N: begin
          wb_memWrData <= m_row;
          wr_ok        <= |m_oh;
          if (m_err) wb_err <= 1'b1;
        end
        S_WR_D: wb_memAddr <= nd_addr;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysram_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysram_writeback
// Purpose  : Self-checking bench for ysram_writeback against a row-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysram_writeback;

  logic         clock = 1'b0;
  logic         reset;
  logic         valid;
  logic         ready;
  logic [47:0]  y_val;
  logic [10:0]  d_addr, n_addr;
  logic [3:0]   d_oh, n_oh;
  logic [10:0]  mem_addr;
  logic         rd_en, wr_en;
  logic [255:0] wr_data;
  logic [255:0] rd_data = '0;
  logic         done, err;

  logic [255:0] mem     [0:2047];
  logic [255:0] ref_mem [0:2047];
  logic         ref_err;
  int           cyc = 0;
  int           acc_log[$];
  int           tests_run = 0;
  int           fails = 0;

  ysram_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .wb_valid         (valid),
    .wb_ready         (ready),
    .wb_yVal          (y_val),
    .wb_diagAddr      (d_addr),
    .wb_nonDiagAddr   (n_addr),
    .wb_diagOneHot    (d_oh),
    .wb_nonDiagOneHot (n_oh),
    .wb_memAddr       (mem_addr),
    .wb_memRdEn       (rd_en),
    .wb_memWrEn       (wr_en),
    .wb_memWrData     (wr_data),
    .wb_memRdData     (rd_data),
    .wb_done          (done),
    .wb_err           (err)
  );

  always #5 clock = ~clock;

  // SRAM with one-cycle read latency, plus an accept logger
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (wr_en) mem[mem_addr] <= wr_data;
    if (rd_en) rd_data <= mem[mem_addr];
    if (valid && ready) acc_log.push_back(cyc);
  end

  function automatic logic [23:0] ref_neg(input logic [23:0] x);
    int v;
    v = $signed(x);
    v = -v;
    if (v > 8388607) v = 8388607;
    return v[23:0];
  endfunction

  function automatic logic [47:0] ref_negv(input logic [47:0] x);
    return {ref_neg(x[47:24]), ref_neg(x[23:0])};
  endfunction

  function automatic logic [255:0] ref_apply(input logic [255:0] row, input logic [3:0] oh,
                                             input logic [47:0] v);
    for (int k = 0; k < 4; k++)
      if (oh[k]) begin
        row[64*k +: 48] = v;
        return row;
      end
    return row;
  endfunction

  function automatic logic oh_bad(input logic [3:0] oh);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) n += oh[k];
    return n != 1;
  endfunction

  function automatic logic [3:0] rand_oh();
    if ($urandom_range(0, 5) == 0) return 4'($urandom);
    return 4'b0001 << $urandom_range(0, 3);
  endfunction

  task automatic run_req(input logic [10:0] d, input logic [10:0] n, input logic [3:0] doh,
                         input logic [3:0] noh, input logic [47:0] yv);
    logic exp_wr, exp_rd;
    logic [10:0] exp_addr;
    valid = 1'b1; d_addr = d; n_addr = n; d_oh = doh; n_oh = noh; y_val = yv;
    @(posedge clock); #1;
    valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      exp_wr = (c == 3 && doh != 0) || (c == 6 && noh != 0);
      exp_rd = (c == 1 || c == 4);
      tests_run++;
      if (wr_en !== exp_wr) begin
        fails++; $display("FAIL wr_en c%0d: got %b exp %b", c, wr_en, exp_wr);
      end
      tests_run++;
      if (rd_en !== exp_rd) begin
        fails++; $display("FAIL rd_en c%0d: got %b exp %b", c, rd_en, exp_rd);
      end
      if (c == 1 || c == 3 || c == 4 || c == 6) begin
        exp_addr = (c <= 3) ? d : n;
        tests_run++;
        if (mem_addr !== exp_addr) begin
          fails++; $display("FAIL mem_addr c%0d: got %h exp %h", c, mem_addr, exp_addr);
        end
      end
      tests_run++;
      if (done !== (c == 7)) begin
        fails++; $display("FAIL done c%0d: got %b exp %b", c, done, c == 7);
      end
      tests_run++;
      if (ready !== (c >= 7)) begin
        fails++; $display("FAIL ready c%0d: got %b exp %b", c, ready, c >= 7);
      end
      if (c < 8) begin @(posedge clock); #1; end
    end
    ref_mem[d] = ref_apply(ref_mem[d], doh, yv);
    ref_mem[n] = ref_apply(ref_mem[n], noh, ref_negv(yv));
    ref_err = ref_err | oh_bad(doh) | oh_bad(noh);
    tests_run++;
    if (mem[d] !== ref_mem[d]) begin
      fails++; $display("FAIL diag row %0d: got %h exp %h", d, mem[d], ref_mem[d]);
    end
    tests_run++;
    if (mem[n] !== ref_mem[n]) begin
      fails++; $display("FAIL offdiag row %0d: got %h exp %h", n, mem[n], ref_mem[n]);
    end
    tests_run++;
    if (err !== ref_err) begin
      fails++; $display("FAIL err: got %b exp %b", err, ref_err);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({ready, rd_en, wr_en, done, err} !== 5'b10000) begin
      fails++; $display("FAIL reset strobes: got %b exp 10000", {ready, rd_en, wr_en, done, err});
    end
    tests_run++;
    if (mem_addr !== 11'd0 || wr_data !== 256'd0) begin
      fails++; $display("FAIL reset regs: got %h/%h exp 0/0", mem_addr, wr_data);
    end
  endtask

  task automatic test_basic();
    run_req(11'd5, 11'd9, 4'b0001, 4'b0100, {24'h000010, 24'hFFFFF0});
    tests_run++;
    if (mem[5][47:0] !== 48'h000010_FFFFF0) begin
      fails++; $display("FAIL basic diag: got %h exp 000010fffff0", mem[5][47:0]);
    end
    tests_run++;
    if (mem[9][175:128] !== 48'hFFFFF0_000010) begin
      fails++; $display("FAIL basic offdiag: got %h exp fffff0000010", mem[9][175:128]);
    end
  endtask

  task automatic test_same_row();
    logic [47:0] yv;
    yv = {16'($urandom), 32'($urandom)};
    run_req(11'd3, 11'd3, 4'b0001, 4'b1000, yv);
    tests_run++;
    if (mem[3][47:0] !== yv || mem[3][239:192] !== ref_negv(yv)) begin
      fails++; $display("FAIL same_row: got %h/%h exp %h/%h", mem[3][47:0], mem[3][239:192],
                        yv, ref_negv(yv));
    end
  endtask

  task automatic test_saturation();
    run_req(11'd12, 11'd13, 4'b0010, 4'b0001, {24'h800000, 24'h000001});
    tests_run++;
    if (mem[13][47:0] !== 48'h7FFFFF_FFFFFF) begin
      fails++; $display("FAIL saturation: got %h exp 7fffffffffff", mem[13][47:0]);
    end
  endtask

  task automatic test_bad_onehot();
    logic [47:0] yv;
    tests_run++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL err_pre: got %b exp 0", err);
    end
    run_req(11'd20, 11'd21, 4'b0001, 4'b0000, {16'($urandom), 32'($urandom)});
    yv = {16'($urandom), 32'($urandom)};
    run_req(11'd22, 11'd23, 4'b0110, 4'b0010, yv);
    tests_run++;
    if (mem[22][111:64] !== yv) begin
      fails++; $display("FAIL multi_oh slot1: got %h exp %h", mem[22][111:64], yv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_req(11'($urandom_range(0, 15)), 11'($urandom_range(0, 15)), rand_oh(), rand_oh(),
              {16'($urandom), 32'($urandom)});
  endtask

  task automatic test_back_to_back();
    logic [10:0] qd[3], qn[3];
    logic [3:0]  qdo[3], qno[3];
    logic [47:0] qv[3];
    int w;
    acc_log.delete();
    for (int i = 0; i < 3; i++) begin
      qd[i] = 11'($urandom_range(30, 33)); qn[i] = 11'($urandom_range(30, 33));
      qdo[i] = 4'b0001 << $urandom_range(0, 3); qno[i] = 4'b0001 << $urandom_range(0, 3);
      qv[i] = {16'($urandom), 32'($urandom)};
    end
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_addr = qd[i]; n_addr = qn[i]; d_oh = qdo[i]; n_oh = qno[i]; y_val = qv[i];
      w = 0;
      while (!ready && w < 20) begin @(posedge clock); #1; w++; end
      if (w >= 20) begin
        tests_run++; fails++; $display("FAIL b2b ready timeout: got 0 exp 1");
      end
      @(posedge clock); #1;
    end
    valid = 1'b0;
    w = 0;
    while (!done && w < 20) begin @(posedge clock); #1; w++; end
    tests_run++;
    if (!done) begin
      fails++; $display("FAIL b2b done timeout: got 0 exp 1");
    end
    tests_run++;
    if (acc_log.size() != 3) begin
      fails++; $display("FAIL b2b accepts: got %0d exp 3", acc_log.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests_run++;
        if (acc_log[i] - acc_log[i-1] != 7) begin
          fails++; $display("FAIL b2b spacing: got %0d exp 7", acc_log[i] - acc_log[i-1]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      ref_mem[qd[i]] = ref_apply(ref_mem[qd[i]], qdo[i], qv[i]);
      ref_mem[qn[i]] = ref_apply(ref_mem[qn[i]], qno[i], ref_negv(qv[i]));
    end
    for (int r = 30; r <= 33; r++) begin
      tests_run++;
      if (mem[r] !== ref_mem[r]) begin
        fails++; $display("FAIL b2b row %0d: got %h exp %h", r, mem[r], ref_mem[r]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] yv;
    yv = {16'($urandom), 32'($urandom)};
    valid = 1'b1; d_addr = 11'd40; n_addr = 11'd41; d_oh = 4'b0001; n_oh = 4'b0001; y_val = yv;
    @(posedge clock); #1;
    valid = 1'b0;
    for (int c = 1; c < 5; c++) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({ready, rd_en, wr_en, done, err} !== 5'b10000) begin
      fails++; $display("FAIL mid_reset strobes: got %b exp 10000", {ready, rd_en, wr_en, done, err});
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      tests_run++;
      if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
        fails++; $display("FAIL mid_reset hold: got %b%b exp 00", wr_en, rd_en);
      end
    end
    #2 reset = 1'b0;
    @(posedge clock); #1;
    ref_err = 1'b0;
    ref_mem[40] = ref_apply(ref_mem[40], 4'b0001, yv);
    tests_run++;
    if (ready !== 1'b1 || mem[40] !== ref_mem[40] || mem[41] !== ref_mem[41]) begin
      fails++; $display("FAIL mid_reset state: got rdy=%b r41=%h exp rdy=1 r41=%h",
                        ready, mem[41], ref_mem[41]);
    end
    run_req(11'd41, 11'd42, 4'b0100, 4'b1000, {16'($urandom), 32'($urandom)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 2048; r++) begin
      mem[r]     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ref_mem[r] = mem[r];
    end
    ref_err = 1'b0;
    reset = 1'b1; valid = 1'b0; y_val = '0;
    d_addr = '0; n_addr = '0; d_oh = '0; n_oh = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    #2 reset = 1'b0;
    @(posedge clock); #1;
    test_basic();
    test_same_row();
    test_saturation();
    test_bad_onehot();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
